dmc_fill_ctrl: RTL and testbench

- Sequencing controller for the 32-line x 16-byte direct-mapped instruction cache.
- Accepts 64-bit fetch requests from the CPU side and performs the hit check.
- On a miss, runs a 4-beat 32-bit line-fill burst from external memory (flash/QSPI side), writes the assembled 128-bit line into the cache, then replays the lookup.
- Sits between the core fetch port, the cache array, and the memory read master.

---
 rtl/dmc_pkg.sv | 18 +
 rtl/dmc_line_assembler.sv | 32 +++
 rtl/dmc_fill_ctrl.sv | 112 +++++++++++
 tb/tb_dmc_fill_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmc_pkg.sv
// dmc_pkg: state encoding and cache geometry shared by the I-cache fill controller.
package dmc_pkg;
    localparam int LINE_W      = 128;
    localparam int BEATS       = LINE_W / 32;
    localparam int OFFSET_BITS = 4;
    localparam int INDEX_BITS  = 5;
    localparam int TAG_BITS    = 15;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] FILL  = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;
    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_CHECK = CHECK,
        ST_FILL  = FILL,
        ST_WRITE = WRITE
    } state_e;
endpackage

// File: rtl/dmc_line_assembler.sv
// dmc_line_assembler: beat counter and line buffer that assembles memory beats into one cache line.
module dmc_line_assembler #(
    parameter int MEM_DW = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              beat_i,
    input  logic [MEM_DW-1:0] data_i,
    output logic [LINE_W-1:0] line_o,
    output logic              last_o
);
    import dmc_pkg::*;
    localparam int NB = LINE_W / MEM_DW;
    localparam int CW = $clog2(NB);
    logic [CW-1:0]     cnt_q;
    logic [LINE_W-1:0] line_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (beat_i) begin
            line_q[cnt_q*MEM_DW +: MEM_DW] <= data_i;
            cnt_q                          <= cnt_q + CW'(1);
        end
    end
    assign line_o = line_q;
    assign last_o = beat_i && (cnt_q == CW'(NB - 1));
endmodule

// File: rtl/dmc_fill_ctrl.sv
// dmc_fill_ctrl: hit-check and 4-beat line-fill sequencer for the 32x16B direct-mapped I-cache.
// Define DMC_FILL_CTRL_PERF_EN to add saturating perf_hits/perf_misses counters.
module dmc_fill_ctrl #(
    parameter int AW     = 24,
    parameter int MEM_DW = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [AW-1:0]     cpu_addr,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic [63:0]       cpu_rdata,
    output logic [AW-1:0]     c_A,
    output logic [AW-1:0]     c_A_h,
    input  logic [63:0]       c_Do,
    input  logic              c_hit,
    output logic [LINE_W-1:0] c_line,
    output logic              c_wr,
    output logic              mem_req,
    output logic [AW-1:0]     mem_addr,
    input  logic [MEM_DW-1:0] mem_rdata,
    input  logic              mem_rvalid
`ifdef DMC_FILL_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_misses
`endif
);
    import dmc_pkg::*;
    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic [63:0]   rdata_q;
    logic          ready_q, done_q, wr_q, mreq_q;
    logic          fill_start, beat, last_beat;
    assign fill_start = (state_q == ST_CHECK) && !c_hit;
    assign beat       = (state_q == ST_FILL) && mem_rvalid;
    dmc_line_assembler #(.MEM_DW(MEM_DW), .LINE_W(LINE_W)) u_asm (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (fill_start),
        .beat_i (beat),
        .data_i (mem_rdata),
        .line_o (c_line),
        .last_o (last_beat)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rdata_q <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            wr_q    <= 1'b0;
            mreq_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            wr_q   <= 1'b0;
            case (state_q)
                ST_IDLE: if (cpu_req) begin
                    addr_q  <= cpu_addr;
                    ready_q <= 1'b0;
                    state_q <= ST_CHECK;
                end
                ST_CHECK: if (c_hit) begin
                    rdata_q <= c_Do;
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end else begin
                    mreq_q  <= 1'b1;
                    state_q <= ST_FILL;
                end
                ST_FILL: if (last_beat) begin
                    mreq_q  <= 1'b0;
                    wr_q    <= 1'b1;
                    state_q <= ST_WRITE;
                end
                ST_WRITE: state_q <= ST_CHECK;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end
    assign cpu_ready = ready_q;
    assign cpu_done  = done_q;
    assign cpu_rdata = rdata_q;
    assign c_wr      = wr_q;
    assign mem_req   = mreq_q;
    assign c_A       = addr_q;
    assign c_A_h     = addr_q;
    assign mem_addr  = {addr_q[AW-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
`ifdef DMC_FILL_CTRL_PERF_EN
    // replay_q marks the post-fill CHECK so its hit is not counted twice
    logic        replay_q;
    logic [31:0] hits_q, misses_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            replay_q <= 1'b0;
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            if (state_q == ST_IDLE) replay_q <= 1'b0;
            else if (state_q == ST_WRITE) replay_q <= 1'b1;
            if ((state_q == ST_CHECK) && c_hit && !replay_q && (hits_q != '1)) hits_q <= hits_q + 32'd1;
            if (fill_start && (misses_q != '1)) misses_q <= misses_q + 32'd1;
        end
    end
    assign perf_hits   = hits_q;
    assign perf_misses = misses_q;
`endif
endmodule

// File: tb/tb_dmc_fill_ctrl.sv
// tb_dmc_fill_ctrl: randomized bench with a cache array model, a memory responder and a line-residency reference model.
module tb_dmc_fill_ctrl;
    localparam int AW = 24;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_ready, cpu_done, c_wr, mem_req, c_hit;
    logic [63:0]   cpu_rdata, c_Do;
    logic [AW-1:0] c_A, c_A_h, mem_addr;
    logic [127:0]  c_line;
    logic [31:0]   mem_rdata = '0;
    logic          mem_rvalid = 1'b0;
`ifdef DMC_FILL_CTRL_PERF_EN
    logic [31:0]   perf_hits, perf_misses;
`endif
    int errors = 0;
    int checks = 0;
    int wr_total = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    logic [127:0] cache_d [32];
    logic [14:0]  cache_t [32];
    bit           cache_v [32];
    logic [23:0]  res_line [32];
    bit           res_v [32];
    logic [31:0]  dir [logic [23:0]];

    dmc_fill_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_ready  (cpu_ready),
        .cpu_done   (cpu_done),
        .cpu_rdata  (cpu_rdata),
        .c_A        (c_A),
        .c_A_h      (c_A_h),
        .c_Do       (c_Do),
        .c_hit      (c_hit),
        .c_line     (c_line),
        .c_wr       (c_wr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
`ifdef DMC_FILL_CTRL_PERF_EN
        ,
        .perf_hits  (perf_hits),
        .perf_misses(perf_misses)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        c_hit = cache_v[c_A_h[8:4]] && (cache_t[c_A_h[8:4]] == c_A_h[23:9]);
        c_Do  = c_A[3] ? cache_d[c_A[8:4]][127:64] : cache_d[c_A[8:4]][63:0];
    end

    always @(posedge clk) begin
        if (c_wr) begin
            cache_d[c_A[8:4]] <= c_line;
            cache_t[c_A[8:4]] <= c_A[23:9];
            cache_v[c_A[8:4]] <= 1'b1;
            wr_total          <= wr_total + 1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [23:0] a);
        logic [23:0] w;
        w = {a[23:2], 2'b00};
        if (dir.exists(w)) return dir[w];
        return {w[11:0], 4'h9, w[23:12], 4'h6} ^ 32'hA5C3_0F1E;
    endfunction

    // Issue one fetch at the current negedge and play memory until cpu_done.
    task automatic fetch(input logic [23:0] a, input int gmin, input int gmax);
        logic [23:0]  base;
        logic [127:0] line_e;
        logic [63:0]  exp_d;
        bit           miss, seen_req, drop, done;
        int           cyc, beats, gap, idle, last_cyc, wrs, lat, busy_ready;
        base   = {a[23:4], 4'h0};
        miss   = !(res_v[a[8:4]] && res_line[a[8:4]] == base);
        line_e = {rd(base + 24'd12), rd(base + 24'd8), rd(base + 24'd4), rd(base)};
        exp_d  = a[3] ? line_e[127:64] : line_e[63:0];
        seen_req = 0; drop = 0; done = 0;
        cyc = 0; beats = 0; idle = 0; last_cyc = 0; wrs = 0; lat = 0; busy_ready = 0;
        gap = $urandom_range(gmin, gmax);
        chk("ready_at_req", cpu_ready, 1);
        cpu_req  = 1'b1;
        cpu_addr = a;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            mem_rvalid = 1'b0;
            if (cpu_done) begin
                done = 1;
                lat  = cyc;
                chk("rdata", cpu_rdata, exp_d);
                chk("ready_with_done", cpu_ready, 1);
            end else begin
                if (cpu_ready) busy_ready++;
                cpu_req  = !cpu_ready && ($urandom_range(0, 1) == 1);
                cpu_addr = 24'($urandom);
                if (c_wr) begin
                    wrs++;
                    chk("c_line", c_line, line_e);
                end
                if (mem_req) begin
                    if (!seen_req) chk("mem_addr", mem_addr, base);
                    seen_req = 1;
                    if (beats < 4) begin
                        if (idle >= gap) begin
                            mem_rvalid = 1'b1;
                            mem_rdata  = rd(base + 24'(4 * beats));
                            beats++;
                            idle = 0;
                            gap  = $urandom_range(gmin, gmax);
                            if (beats == 4) last_cyc = cyc;
                        end else begin
                            idle++;
                            mem_rdata = $urandom;
                        end
                    end
                end else begin
                    if (seen_req && beats < 4) drop = 1;
                    mem_rvalid = ($urandom_range(0, 1) == 1);
                    mem_rdata  = $urandom;
                end
            end
        end
        cpu_req    = 1'b0;
        mem_rvalid = 1'b0;
        chk("done_seen", done, 1);
        chk("miss", seen_req, miss);
        chk("beats", beats, miss ? 4 : 0);
        chk("c_wr_count", wrs, miss ? 1 : 0);
        chk("latency", lat, miss ? last_cyc + 3 : 2);
        chk("req_held", drop, 0);
        chk("ready_busy", busy_ready, 0);
        if (miss) begin
            res_v[a[8:4]]    = 1;
            res_line[a[8:4]] = base;
            exp_misses++;
        end else begin
            exp_hits++;
        end
    endtask

    task automatic fill_abort(input logic [23:0] a);
        logic [23:0] base;
        int          beats, cyc, wr0;
        base  = {a[23:4], 4'h0};
        wr0   = wr_total;
        beats = 0;
        cyc   = 0;
        cpu_req  = 1'b1;
        cpu_addr = a;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        while (beats < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            mem_rvalid = mem_req;
            mem_rdata  = rd(base + 24'(4 * beats));
            if (mem_req) beats++;
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("abort_req_before", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_mem_req", mem_req, 0);
        chk("abort_ready", cpu_ready, 1);
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
        @(negedge clk);
        mem_rvalid = 1'b0;
        rst_n      = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_no_wr", wr_total, wr0);
        chk("abort_idle_ready", cpu_ready, 1);
        chk("abort_idle_req", mem_req, 0);
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic perf_check();
`ifdef DMC_FILL_CTRL_PERF_EN
        chk("perf_hits", perf_hits, exp_hits);
        chk("perf_misses", perf_misses, exp_misses);
`endif
    endtask

    initial begin
        dir[24'h000120] = 32'h1111_1111;
        dir[24'h000124] = 32'h2222_2222;
        dir[24'h000128] = 32'h3333_3333;
        dir[24'h00012C] = 32'h4444_4444;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", cpu_ready, 1);
        chk("rst_done", cpu_done, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_c_wr", c_wr, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_c_A", c_A, 0);
        chk("rst_c_A_h", c_A_h, 0);
        chk("rst_c_line", c_line, 0);
        chk("rst_mem_addr", mem_addr, 0);
        perf_check();
        fetch(24'h000120, 0, 0);
        chk("cold_rdata", cpu_rdata, 64'h2222_2222_1111_1111);
        fetch(24'h000128, 0, 0);
        chk("hit_rdata", cpu_rdata, 64'h4444_4444_3333_3333);
        fetch(24'h000320, 0, 0);
        fetch(24'h000120, 3, 3);
        perf_check();
        fill_abort(24'h000540);
        perf_check();
        fetch(24'h000540, 0, 0);
        for (int i = 0; i < 40; i++)
            fetch({15'($urandom_range(0, 2)), 5'(8 + $urandom_range(0, 3)), 4'($urandom)}, 0, 3);
        perf_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
